// File: rtl/minterm_scanner.sv
// Steps vec through codes 0..15, holding each SETTLE+1 cycles, captures f_in into tt and
// compares the completed truth table against EXPECT. All outputs are registered.
module minterm_scanner #(
  parameter int          SETTLE = 1,
  parameter logic [15:0] EXPECT = 16'hB0A0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [4:0]  ones,
  output logic        mismatch
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [15:0] w_tt_next;

  // Table as it will look after the current sample; mismatch must see the final bit.
  always_comb begin
    w_tt_next      = tt;
    w_tt_next[vec] = f_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      vec      <= 4'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tt       <= 16'd0;
      ones     <= 5'd0;
      mismatch <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !abort) begin
            r_state  <= SCAN;
            busy     <= 1'b1;
            tt       <= 16'd0;
            ones     <= 5'd0;
            mismatch <= 1'b0;
            r_cnt    <= 4'd0;
            vec      <= 4'd0;
          end
        end
        SCAN: begin
          if (abort) begin
            r_state  <= IDLE;
            busy     <= 1'b0;
            mismatch <= 1'b0;
          end else if (r_cnt == LP_SETTLE) begin
            r_cnt <= 4'd0;
            tt    <= w_tt_next;
            ones  <= ones + {4'd0, f_in};
            if (vec == 4'd15) begin
              r_state  <= FIN;
              busy     <= 1'b0;
              done     <= 1'b1;
              mismatch <= (w_tt_next != EXPECT);
            end else begin
              vec <= vec + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_minterm_scanner.sv
// Directed bench for minterm_scanner: table of full scans plus abort/reset/start-hold sequences.
module tb_minterm_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] f_table;
  logic        f_in;
  logic [3:0]  vec;
  logic        busy, done, mismatch;
  logic [15:0] tt;
  logic [4:0]  ones;

  logic        start0, abort0;
  logic        f_in0;
  logic [3:0]  vec0;
  logic        busy0, done0, mismatch0;
  logic [15:0] tt0;
  logic [4:0]  ones0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign f_in  = f_table[vec];
  assign f_in0 = 1'b1;

  minterm_scanner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
    .vec(vec), .busy(busy), .done(done), .tt(tt), .ones(ones), .mismatch(mismatch)
  );

  minterm_scanner #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .f_in(f_in0),
    .vec(vec0), .busy(busy0), .done(done0), .tt(tt0), .ones(ones0), .mismatch(mismatch0)
  );

  task automatic check(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  // Full scan on the SETTLE=1 instance, checking latency, vec stepping and results.
  task automatic run_scan(input string nm, input logic [15:0] ft, input logic hold,
                          input logic [15:0] e_tt, input int e_ones, input logic e_mm);
    int n;
    bit seq_ok;
    seq_ok  = 1'b1;
    n       = 0;
    f_table = ft;
    start   = 1'b1;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!hold) start = 1'b0;
      if (done) break;
      if (busy !== 1'b1 || vec !== 4'((n - 1) / 2)) seq_ok = 1'b0;
    end
    start = 1'b0;
    check({nm, "_latency"}, n, 33);
    check({nm, "_vec_seq"}, int'(seq_ok), 1);
    check({nm, "_tt"}, int'(tt), int'(e_tt));
    check({nm, "_ones"}, int'(ones), e_ones);
    check({nm, "_mismatch"}, int'(mismatch), int'(e_mm));
    check({nm, "_busy_fin"}, int'(busy), 0);
    check({nm, "_vec_fin"}, int'(vec), 15);
    @(negedge clk);
    @(negedge clk);
    check({nm, "_done_pulse"}, int'(done), 0);
    check({nm, "_tt_hold"}, int'(tt), int'(e_tt));
    check({nm, "_idle"}, int'(busy), 0);
  endtask

  typedef struct {
    string       nm;
    logic [15:0] ft;
    logic [15:0] e_tt;
    int          e_ones;
    logic        e_mm;
  } scan_vec_t;

  initial begin
    scan_vec_t tbl[5];
    int n;
    tbl[0] = '{"correct",  16'hB0A0, 16'hB0A0, 5,  1'b0};
    tbl[1] = '{"code13_0", 16'h90A0, 16'h90A0, 4,  1'b1};
    tbl[2] = '{"zeros",    16'h0000, 16'h0000, 0,  1'b1};
    tbl[3] = '{"only0",    16'h0001, 16'h0001, 1,  1'b1};
    tbl[4] = '{"ones",     16'hFFFF, 16'hFFFF, 16, 1'b1};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; f_table = 16'hB0A0;
    start0 = 1'b0; abort0 = 1'b0;
    #1;
    check("rst_vec", int'(vec), 0);
    check("rst_busy_done", int'({busy, done}), 0);
    check("rst_tt_ones_mm", int'({tt, ones, mismatch}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_scan(tbl[i].nm, tbl[i].ft, 1'b0, tbl[i].e_tt, tbl[i].e_ones, tbl[i].e_mm);

    // start with abort in IDLE must not begin a scan
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", int'(busy), 0);
    @(negedge clk);
    check("start_abort_idle_busy2", int'(busy), 0);

    // abort while vec=6
    f_table = 16'hB0A0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec != 4'd6 && n < 100) begin @(negedge clk); n++; end
    check("abort_reach_vec6", int'(vec), 6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_tt", int'(tt), 16'h0020);
    check("abort_ones", int'(ones), 1);
    check("abort_vec", int'(vec), 6);
    check("abort_mismatch", int'(mismatch), 0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (done || busy) n++;
      @(negedge clk);
    end
    check("abort_no_done", n, 0);
    run_scan("after_abort", 16'hB0A0, 1'b0, 16'hB0A0, 5, 1'b0);

    // asynchronous reset between edges while vec=9
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec != 4'd9 && n < 100) begin @(negedge clk); n++; end
    check("rstmid_reach_vec9", int'(vec), 9);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid_vec", int'(vec), 0);
    check("rstmid_busy_done", int'({busy, done}), 0);
    check("rstmid_tt_ones_mm", int'({tt, ones, mismatch}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstmid_stays_idle", int'({busy, vec}), 0);
    run_scan("start_held", 16'hB0A0, 1'b1, 16'hB0A0, 5, 1'b0);

    // SETTLE=0 instance with f_in tied high
    start0 = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      start0 = 1'b0;
      if (done0) break;
    end
    check("s0_latency", n, 17);
    check("s0_tt", int'(tt0), 16'hFFFF);
    check("s0_ones", int'(ones0), 16);
    check("s0_mismatch", int'(mismatch0), 1);
    @(negedge clk);
    check("s0_done_pulse", int'({done0, busy0}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/minterm_scanner.md
MINTERM_SCANNER -- requirements
Module: minterm_scanner

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, giving the number of extra cycles each code is held before F is sampled (legal range 0..15).
REQ-002 The block SHALL have parameter EXPECT, default 16'hB0A0, the expected truth table (bit i = F for code i; minterms 5, 7, 12, 13, 15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a full scan; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel a scan in progress.
REQ-007 The block SHALL have port f_in, input, 1 bit: F returned by the downstream 4-input function stage for the code on vec.
REQ-008 The block SHALL have port vec, output, 4 bits: code {A,B,C,D} driven to the function stage, with A as the MSB.
REQ-009 The block SHALL have port busy, output, 1 bit: high while in state SCAN.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a scan completes.
REQ-011 The block SHALL have port tt, output, 16 bits: captured truth table, bit i = sampled F for code i.
REQ-012 The block SHALL have port ones, output, 5 bits: count of 1 bits captured in tt (0..16).
REQ-013 The block SHALL have port mismatch, output, 1 bit: high when the completed tt differs from EXPECT.

Function
REQ-014 FSM states SHALL be IDLE, SCAN and FIN; all outputs SHALL be registered.
REQ-015 IDLE with start=1 and abort=0 at an edge SHALL go to SCAN, clear tt, ones, mismatch and the settle counter, and set vec=0.
REQ-016 In SCAN, each code SHALL be held on vec for exactly SETTLE+1 cycles, and f_in SHALL be sampled into tt[vec] on the last edge of the hold.
REQ-017 At that same edge, ones SHALL increment by f_in and vec SHALL advance by 1; if vec was 15, vec SHALL stay 15 and the state SHALL go to FIN.
REQ-018 A full scan SHALL take 16*(SETTLE+1) cycles in SCAN; vec SHALL never wrap to 0 within a scan.
REQ-019 FIN SHALL last one cycle with done=1, busy=0 and mismatch=(tt!=EXPECT), then return to IDLE.
REQ-020 tt, ones and mismatch SHALL hold their values in IDLE until the next accepted start.
REQ-021 start while in SCAN or FIN SHALL be ignored (no restart, no queuing).
REQ-022 abort=1 in SCAN SHALL return the state to IDLE on the next edge, with no done pulse, mismatch=0, the partial tt and ones retained, and vec unchanged.
REQ-023 abort has priority over start; start=1 and abort=1 together in IDLE SHALL leave the block in IDLE.
REQ-024 abort in FIN SHALL be ignored; the done pulse still completes.
REQ-025 f_in SHALL be ignored on every cycle other than the sample edge.

Reset
REQ-026 When rst_n=0, the block SHALL immediately, independent of clk, set state=IDLE, vec=0, busy=0, done=0, tt=0, ones=0, mismatch=0 and the settle counter to 0.
REQ-027 Reset asserted mid-scan SHALL discard all progress; after release the block SHALL wait in IDLE for a new start.

Verification
REQ-028 Default parameters, f_in driven by the correct F stage, start pulse: vec steps 0..15, each held 2 cycles; done pulses 33 cycles after start; tt=16'hB0A0, ones=5, mismatch=0.
REQ-029 f_in tied to 1, SETTLE=0: done pulses 17 cycles after start; tt=16'hFFFF, ones=16, mismatch=1.
REQ-030 F stage with code 13 forced to 0: tt=16'h90A0, ones=4, mismatch=1.
REQ-031 abort while vec=6 (correct F stage): busy falls the next cycle, no done pulse, tt=16'h0020, ones=1; a later start yields a clean full scan.
REQ-032 rst_n pulsed low asynchronously (between edges) while vec=9: all outputs are 0 immediately; start held high throughout a later scan causes no restart.
